// File: rtl/pipe_pkg.sv
// Shared types for the pipeline hazard controller: scoreboard entry layout and
// forwarding-select constants.
package pipe_pkg;

  localparam int SB_AW = 8;

  typedef struct packed {
    logic             valid;
    logic             wr_en;
    logic [SB_AW-1:0] addr;
    logic             is_load;
  } sb_entry_t;

  typedef logic [7:0] fwd_sel_t;

  localparam fwd_sel_t  FWD_NONE  = '0;
  localparam sb_entry_t SB_BUBBLE = '0;

  // Register 0 is hard-wired, so a write to it is never a forwarding source.
  function automatic logic sb_hit(input sb_entry_t e, input logic [SB_AW-1:0] a);
    return e.valid && e.wr_en && (e.addr == a) && (a != '0);
  endfunction

endpackage

// File: rtl/pipe_fwd_match.sv
// Single read-port priority matcher: picks the youngest in-flight producer of
// the port's register and reports a load that is still too young to forward.
module pipe_fwd_match
  import pipe_pkg::*;
#(
  parameter int REG_AW    = 5,
  parameter int FWD_DEPTH = 2,
  parameter int SELW      = 2
) (
  input  logic                  [REG_AW-1:0] i_addr,
  input  logic                               i_used,
  input  sb_entry_t [FWD_DEPTH-1:0]          i_sb,
  output logic                  [SELW-1:0]   o_sel,
  output logic                               o_load_hit
);

  logic w_found;

  // Lowest index is the youngest producer; a load only has data from MEM/WB on.
  always_comb begin
    o_sel      = FWD_NONE[SELW-1:0];
    o_load_hit = 1'b0;
    w_found    = 1'b0;
    for (int j = 0; j < FWD_DEPTH; j++) begin
      if (!w_found && i_used && sb_hit(i_sb[j], SB_AW'(i_addr))) begin
        w_found = 1'b1;
        if (i_sb[j].is_load && (j + 1 < 2))
          o_load_hit = 1'b1;
        else
          o_sel = SELW'(j + 1);
      end
    end
  end

endmodule

// File: rtl/pipe_hazard_unit.sv
// In-order pipeline hazard controller: forwarding selects, load-use stall and
// redirect flush. Define PIPE_HAZARD_STATS_EN to add stall/flush cycle counters.
module pipe_hazard_unit
  import pipe_pkg::*;
#(
  parameter int REG_AW        = 5,
  parameter int NUM_RD        = 2,
  parameter int FWD_DEPTH     = 2,
  parameter int RESOLVE_STAGE = 1,
  parameter int SELW          = $clog2(FWD_DEPTH + 1)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     id_valid,
  input  logic [NUM_RD*REG_AW-1:0] id_rd_addr,
  input  logic [NUM_RD-1:0]        id_rd_used,
  input  logic                     id_wr_en,
  input  logic [REG_AW-1:0]        id_wr_addr,
  input  logic                     id_is_load,
  input  logic                     redirect,
  output logic [NUM_RD*SELW-1:0]   ex_fwd_sel,
  output logic                     stall,
  output logic                     flush
`ifdef PIPE_HAZARD_STATS_EN
  ,
  output logic [31:0]              stall_cnt,
  output logic [31:0]              flush_cnt
`endif
);

  // Entries older than the last forwarding stage never feed a select, so the
  // stored window ends at FWD_DEPTH-1.
  sb_entry_t [FWD_DEPTH-1:0] r_sb;
  sb_entry_t [FWD_DEPTH-1:0] w_sb_next;
  logic [NUM_RD*SELW-1:0]    r_ex_fwd_sel;
  logic [NUM_RD*SELW-1:0]    w_sel_raw;
  logic [NUM_RD*SELW-1:0]    w_sel_next;
  logic [NUM_RD-1:0]         w_load_hit;
  logic                      w_stall;
  logic                      w_flush;

  for (genvar p = 0; p < NUM_RD; p++) begin : g_port
    pipe_fwd_match #(
      .REG_AW    (REG_AW),
      .FWD_DEPTH (FWD_DEPTH),
      .SELW      (SELW)
    ) u_match (
      .i_addr     (id_rd_addr[p*REG_AW +: REG_AW]),
      .i_used     (id_rd_used[p]),
      .i_sb       (r_sb),
      .o_sel      (w_sel_raw[p*SELW +: SELW]),
      .o_load_hit (w_load_hit[p])
    );
  end

  assign w_flush    = rst_n & redirect;
  assign w_stall    = rst_n & id_valid & ~redirect & (|w_load_hit);
  assign stall      = w_stall;
  assign flush      = w_flush;
  assign ex_fwd_sel = r_ex_fwd_sel;

  // Shift by one stage; on redirect, everything younger than the resolving
  // instruction is squashed as it moves down.
  always_comb begin
    w_sb_next    = r_sb;
    w_sb_next[0] = SB_BUBBLE;
    if (!w_stall && !w_flush) begin
      w_sb_next[0] = '{valid:   id_valid,
                       wr_en:   id_wr_en,
                       addr:    SB_AW'(id_wr_addr),
                       is_load: id_is_load};
    end
    for (int k = 1; k < FWD_DEPTH; k++) begin
      w_sb_next[k] = r_sb[k-1];
      if (w_flush && (k <= RESOLVE_STAGE))
        w_sb_next[k].valid = 1'b0;
    end
  end

  assign w_sel_next = (w_stall || w_flush || !id_valid) ? '0 : w_sel_raw;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sb         <= '0;
      r_ex_fwd_sel <= '0;
    end else begin
      r_sb         <= w_sb_next;
      r_ex_fwd_sel <= w_sel_next;
    end
  end

`ifdef PIPE_HAZARD_STATS_EN
  logic [31:0] r_stall_cnt;
  logic [31:0] r_flush_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_stall && (r_stall_cnt != '1))
        r_stall_cnt <= r_stall_cnt + 32'd1;
      if (w_flush && (r_flush_cnt != '1))
        r_flush_cnt <= r_flush_cnt + 32'd1;
    end
  end

  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;
`endif

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Self-checking bench for pipe_hazard_unit: directed hazard sequences plus
// randomized traffic against an in-flight instruction list model.
module tb_pipe_hazard_unit;

  localparam int REG_AW        = 5;
  localparam int NUM_RD        = 2;
  localparam int FWD_DEPTH     = 2;
  localparam int RESOLVE_STAGE = 1;
  localparam int SELW          = $clog2(FWD_DEPTH + 1);

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic                     id_valid;
  logic [NUM_RD*REG_AW-1:0] id_rd_addr;
  logic [NUM_RD-1:0]        id_rd_used;
  logic                     id_wr_en;
  logic [REG_AW-1:0]        id_wr_addr;
  logic                     id_is_load;
  logic                     redirect;
  logic [NUM_RD*SELW-1:0]   ex_fwd_sel;
  logic                     stall;
  logic                     flush;
`ifdef PIPE_HAZARD_STATS_EN
  logic [31:0]              stall_cnt;
  logic [31:0]              flush_cnt;
`endif

  always #5 clk = ~clk;

  pipe_hazard_unit #(
    .REG_AW        (REG_AW),
    .NUM_RD        (NUM_RD),
    .FWD_DEPTH     (FWD_DEPTH),
    .RESOLVE_STAGE (RESOLVE_STAGE)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .id_valid   (id_valid),
    .id_rd_addr (id_rd_addr),
    .id_rd_used (id_rd_used),
    .id_wr_en   (id_wr_en),
    .id_wr_addr (id_wr_addr),
    .id_is_load (id_is_load),
    .redirect   (redirect),
    .ex_fwd_sel (ex_fwd_sel),
    .stall      (stall),
    .flush      (flush)
`ifdef PIPE_HAZARD_STATS_EN
    ,
    .stall_cnt  (stall_cnt),
    .flush_cnt  (flush_cnt)
`endif
  );

  int compared   = 0;
  int mismatched = 0;

  // Instructions that have entered EX, tagged with the cycle they did so;
  // distance from EX is simply (cycle - ecyc).
  typedef struct {
    logic [REG_AW-1:0] addr;
    bit                wr;
    bit                ld;
    int                ecyc;
  } rec_t;

  rec_t inflight[$];
  int   cyc         = 0;
  int   expStallCnt = 0;
  int   expFlushCnt = 0;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic modelReset();
    inflight.delete();
    cyc         = 0;
    expStallCnt = 0;
    expFlushCnt = 0;
  endtask

  task automatic modelEval(input bit v, input logic [NUM_RD*REG_AW-1:0] ra, input logic [NUM_RD-1:0] used,
                           input bit redir, output bit st, output logic [NUM_RD*SELW-1:0] sel);
    bit loadUse;
    loadUse = 1'b0;
    sel     = '0;
    for (int p = 0; p < NUM_RD; p++) begin
      logic [REG_AW-1:0] a;
      int                best;
      bit                bestLd;
      a      = ra[p*REG_AW +: REG_AW];
      best   = -1;
      bestLd = 1'b0;
      foreach (inflight[i]) begin
        int d;
        d = cyc - inflight[i].ecyc;
        if (d >= 0 && d < FWD_DEPTH && inflight[i].wr && inflight[i].addr == a && a != 0 &&
            (best < 0 || d < best)) begin
          best   = d;
          bestLd = inflight[i].ld;
        end
      end
      if (v && used[p] && best >= 0) begin
        if (bestLd && best + 1 < 2)
          loadUse = 1'b1;
        else
          sel[p*SELW +: SELW] = SELW'(best + 1);
      end
    end
    st = v && !redir && loadUse;
    if (st || redir || !v)
      sel = '0;
  endtask

  // One ID cycle: drive, check same-cycle stall/flush, clock, check the select
  // the instruction carries into EX. want* < 0 means no directed expectation.
  task automatic applyStimulus(input bit v, input logic [NUM_RD*REG_AW-1:0] ra, input logic [NUM_RD-1:0] used,
                               input bit wr, input logic [REG_AW-1:0] wa, input bit ld, input bit redir,
                               input int wantStall, input int wantSel);
    bit                     st;
    logic [NUM_RD*SELW-1:0] sel;
    rec_t                   r;
    id_valid   = v;
    id_rd_addr = ra;
    id_rd_used = used;
    id_wr_en   = wr;
    id_wr_addr = wa;
    id_is_load = ld;
    redirect   = redir;
    #1;
    modelEval(v, ra, used, redir, st, sel);
    checkOutput("stall", {31'd0, stall}, {31'd0, st});
    checkOutput("flush", {31'd0, flush}, {31'd0, redir});
    if (wantStall >= 0)
      checkOutput("dir_stall", {31'd0, stall}, wantStall);
    @(posedge clk);
    if (st) expStallCnt++;
    if (redir) expFlushCnt++;
    if (redir)
      inflight = inflight.find with (cyc - item.ecyc >= RESOLVE_STAGE);
    cyc++;
    if (v && !st && !redir) begin
      r.addr = wa;
      r.wr   = wr;
      r.ld   = ld;
      r.ecyc = cyc;
      inflight.push_back(r);
    end
    inflight = inflight.find with (cyc - item.ecyc < FWD_DEPTH);
    #1;
    checkOutput("ex_fwd_sel", 32'(ex_fwd_sel), 32'(sel));
    if (wantSel >= 0)
      checkOutput("dir_sel", 32'(ex_fwd_sel), wantSel);
`ifdef PIPE_HAZARD_STATS_EN
    checkOutput("stall_cnt", stall_cnt, expStallCnt);
    checkOutput("flush_cnt", flush_cnt, expFlushCnt);
`endif
    @(negedge clk);
  endtask

  task automatic nop2();
    applyStimulus(0, '0, '0, 0, '0, 0, 0, 0, 0);
    applyStimulus(0, '0, '0, 0, '0, 0, 0, 0, 0);
  endtask

  initial begin
    rst_n      = 1'b0;
    id_valid   = 1'b0;
    id_rd_addr = '0;
    id_rd_used = '0;
    id_wr_en   = 1'b0;
    id_wr_addr = '0;
    id_is_load = 1'b0;
    redirect   = 1'b0;
    #1;
    checkOutput("rst_sel", 32'(ex_fwd_sel), 0);
    checkOutput("rst_stall", {31'd0, stall}, 0);
    checkOutput("rst_flush", {31'd0, flush}, 0);
    modelReset();
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // add r3<-r1,r2 ; sub r4<-r3,r5 back-to-back
    applyStimulus(1, {5'd2, 5'd1}, 2'b11, 1, 5'd3, 0, 0, 0, 0);
    applyStimulus(1, {5'd5, 5'd3}, 2'b11, 1, 5'd4, 0, 0, 0, 4'b0001);
    nop2();

    // producer r3, independent, consumer of r3 on port1
    applyStimulus(1, {5'd2, 5'd1}, 2'b11, 1, 5'd3, 0, 0, 0, -1);
    applyStimulus(1, {5'd8, 5'd7}, 2'b11, 1, 5'd6, 0, 0, 0, -1);
    applyStimulus(1, {5'd3, 5'd9}, 2'b11, 1, 5'd10, 0, 0, 0, 4'b1000);
    nop2();

    // lw r3 ; add r5<-r3,r4 : one bubble, then select 2
    applyStimulus(1, {5'd0, 5'd1}, 2'b01, 1, 5'd3, 1, 0, 0, 0);
    applyStimulus(1, {5'd4, 5'd3}, 2'b11, 1, 5'd5, 0, 0, 1, 0);
    applyStimulus(1, {5'd4, 5'd3}, 2'b11, 1, 5'd5, 0, 0, 0, 4'b0010);
    nop2();

    // writes to r0 never forward or stall
    applyStimulus(1, {5'd2, 5'd1}, 2'b11, 1, 5'd0, 0, 0, 0, 0);
    applyStimulus(1, {5'd0, 5'd0}, 2'b11, 1, 5'd6, 0, 0, 0, 0);
    applyStimulus(1, {5'd0, 5'd1}, 2'b01, 1, 5'd0, 1, 0, 0, 0);
    applyStimulus(1, {5'd0, 5'd0}, 2'b11, 1, 5'd6, 0, 0, 0, 0);
    nop2();

    // add r3 ; lw r3 ; dependent with redirect ; follow-up reader of r3
    applyStimulus(1, {5'd2, 5'd1}, 2'b11, 1, 5'd3, 0, 0, 0, -1);
    applyStimulus(1, {5'd0, 5'd1}, 2'b01, 1, 5'd3, 1, 0, 0, -1);
    applyStimulus(1, {5'd0, 5'd3}, 2'b01, 1, 5'd7, 0, 1, 0, 0);
    applyStimulus(1, {5'd0, 5'd3}, 2'b01, 1, 5'd8, 0, 0, 0, 0);
    nop2();

    // reset asserted while a load-use stall and a redirect are pending
    applyStimulus(1, {5'd0, 5'd1}, 2'b01, 1, 5'd3, 1, 0, 0, -1);
    id_valid   = 1'b1;
    id_rd_addr = {5'd0, 5'd3};
    id_rd_used = 2'b01;
    id_wr_en   = 1'b1;
    id_wr_addr = 5'd4;
    id_is_load = 1'b0;
    #1;
    checkOutput("pre_rst_stall", {31'd0, stall}, 1);
    redirect = 1'b1;
    rst_n    = 1'b0;
    #1;
    checkOutput("midrst_stall", {31'd0, stall}, 0);
    checkOutput("midrst_flush", {31'd0, flush}, 0);
    checkOutput("midrst_sel", 32'(ex_fwd_sel), 0);
`ifdef PIPE_HAZARD_STATS_EN
    checkOutput("midrst_scnt", stall_cnt, 0);
    checkOutput("midrst_fcnt", flush_cnt, 0);
`endif
    modelReset();
    @(posedge clk);
    #1;
    checkOutput("inrst_sel", 32'(ex_fwd_sel), 0);
    @(negedge clk);
    redirect = 1'b0;
    rst_n    = 1'b1;
    applyStimulus(1, {5'd2, 5'd1}, 2'b11, 1, 5'd3, 0, 0, 0, 0);
    applyStimulus(1, {5'd5, 5'd3}, 2'b11, 1, 5'd4, 0, 0, 0, 4'b0001);

    // randomized traffic over a small register set to provoke hazards
    for (int n = 0; n < 400; n++) begin
      logic [NUM_RD*REG_AW-1:0] ra;
      ra = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
      applyStimulus($urandom_range(0, 9) != 0, ra, 2'($urandom_range(0, 3)),
                    $urandom_range(0, 3) != 0, 5'($urandom_range(0, 3)),
                    $urandom_range(0, 2) == 0, $urandom_range(0, 9) == 0, -1, -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
